mem_copy_requester: RTL and testbench

- Initiator for one requester port of the multibank memory: it drives one read port and one write port.
- Accepts a copy command (src, dst, len) and issues pipelined reads starting at src.
- Buffers the returned data in a small FIFO and writes it to dst in order.
- Used by the DMA/test harness to move blocks between memory regions without CPU involvement.

---
 rtl/multimem_pkg.sv | 7 +
 rtl/multimem_sync_fifo.sv | 57 +++++
 rtl/mem_copy_requester.sv | 117 +++++++++++
 tb/tb_mem_copy_requester.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multimem_pkg.sv
// Shared types and default bus widths for the multibank memory and its requesters.
package multimem_pkg;
  localparam int unsigned MM_DATA_WIDTH = 32;
  localparam int unsigned MM_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/multimem_sync_fifo.sv
// Single-clock FIFO with synchronous clear; head shows the oldest entry (first-word fall-through).
module multimem_sync_fifo
  import multimem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MM_DATA_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_ONE = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mem_copy_requester.sv
// Copies len words from src to dst: pipelined credit-limited reads, FIFO-buffered in-order writes.
module mem_copy_requester
  import multimem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = MM_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_avalid,
  input  logic                  r_aready,
  input  logic                  r_dvalid,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [CW-1:0]       OUT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]         DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic [ADDR_WIDTH:0]   len, rd_issued, wr_done;
  logic [CW-1:0]         outstanding, fifo_count;
  logic [CW:0]           inflight;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  accept, rd_hs, wr_hs, ret, fifo_empty, fifo_full;

  // Credit covers both in-flight reads and buffered words, so the FIFO can never overflow.
  assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};
  assign accept   = (state == IDLE) & cmd_valid;
  assign r_avalid = (state == RUN) & (rd_issued < len) & (inflight < DEPTH_LIM);
  assign r_addr   = src + rd_issued[ADDR_WIDTH-1:0];
  assign w_valid  = (state == RUN) & ~fifo_empty;
  assign w_addr   = dst + wr_done[ADDR_WIDTH-1:0];
  assign w_data   = w_valid ? fifo_head : '0;
  assign rd_hs    = r_avalid & r_aready;
  assign wr_hs    = w_valid & w_ready;
  assign ret      = r_dvalid & (outstanding != '0);

  multimem_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .push  (ret & ~fifo_full),
    .pop   (wr_hs),
    .din   (r_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = (cmd_len == '0) ? FIN : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (wr_hs && (wr_done + LEN_ONE == len)) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      src         <= '0;
      dst         <= '0;
      len         <= '0;
      rd_issued   <= '0;
      wr_done     <= '0;
      outstanding <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        src         <= cmd_src;
        dst         <= cmd_dst;
        len         <= cmd_len;
        rd_issued   <= '0;
        wr_done     <= '0;
        outstanding <= '0;
      end else begin
        if (rd_hs) rd_issued <= rd_issued + LEN_ONE;
        if (wr_hs) wr_done   <= wr_done + LEN_ONE;
        if (rd_hs && !ret)      outstanding <= outstanding + OUT_ONE;
        else if (!rd_hs && ret) outstanding <= outstanding - OUT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_mem_copy_requester.sv
// Directed bench for mem_copy_requester against a one-cycle-latency memory model.
module tb_mem_copy_requester;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [AW:0]   cmd_len = '0;
  logic          busy, done;
  logic [AW-1:0] r_addr;
  logic          r_avalid;
  logic          r_aready = 1'b0;
  logic          r_dvalid;
  logic [DW-1:0] r_data;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready = 1'b0;

  always #5 clk = ~clk;

  mem_copy_requester #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .busy      (busy),
    .done      (done),
    .r_addr    (r_addr),
    .r_avalid  (r_avalid),
    .r_aready  (r_aready),
    .r_dvalid  (r_dvalid),
    .r_data    (r_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready)
  );

  // Memory contents: word at address a reads as C0DE_000a.
  function automatic logic [DW-1:0] img(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {28'h0, a};
  endfunction

  logic          rv_q = 1'b0;
  logic [DW-1:0] rd_q = '0;
  logic          inj_v = 1'b0;
  logic [DW-1:0] inj_d = '0;
  assign r_dvalid = rv_q | inj_v;
  assign r_data   = inj_v ? inj_d : rd_q;

  always @(posedge clk) begin
    rv_q <= r_avalid & r_aready;
    rd_q <= img(r_addr);
  end

  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wa_log[$];
  logic [DW-1:0] wd_log[$];
  always @(posedge clk) begin
    if (rst) begin
      if (r_avalid && r_aready) rd_log.push_back(r_addr);
      if (w_valid && w_ready) begin
        wa_log.push_back(w_addr);
        wd_log.push_back(w_data);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    int          whold;
    bit          ratog;
    int          exp_done_k;
    int          exp_hold_reads;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int done_k, done_cnt, r_viol, w_viol, hold_reads;
    logic p_rav, p_wv, p_rrdy, p_wrdy;
    logic [AW-1:0] p_ra, p_wa;
    logic [DW-1:0] p_wd;
    logic [AW-1:0] ea;
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
    chk({v.name, " idle cmd_ready"}, cmd_ready, 1);
    cmd_src   = v.src;
    cmd_dst   = v.dst;
    cmd_len   = v.len;
    cmd_valid = 1'b1;
    r_aready  = 1'b1;
    w_ready   = (v.whold == 0);
    p_rav = 1'b0; p_wv = 1'b0; p_rrdy = r_aready; p_wrdy = w_ready;
    p_ra = '0; p_wa = '0; p_wd = '0;
    done_k = 0; done_cnt = 0; r_viol = 0; w_viol = 0; hold_reads = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
      if (p_rav && !p_rrdy && (r_avalid !== 1'b1 || r_addr !== p_ra)) r_viol++;
      if (p_wv && !p_wrdy && (w_valid !== 1'b1 || w_addr !== p_wa || w_data !== p_wd)) w_viol++;
      if (k == v.whold) begin
        hold_reads = rd_log.size();
        chk({v.name, " r_avalid low when full"}, r_avalid, 0);
        chk({v.name, " w_valid held"}, w_valid, 1);
      end
      if (done_k != 0 && k == done_k + 1) begin
        chk({v.name, " cmd_ready after done"}, cmd_ready, 1);
        chk({v.name, " busy after done"}, busy, 0);
      end
      if (done_k != 0 && k >= done_k + 3) break;
      p_rav = r_avalid; p_ra = r_addr;
      p_wv = w_valid; p_wa = w_addr; p_wd = w_data;
      r_aready = v.ratog ? ((k % 2) == 0) : 1'b1;
      w_ready  = (k >= v.whold);
      p_rrdy = r_aready;
      p_wrdy = w_ready;
    end
    w_ready  = 1'b1;
    r_aready = 1'b1;
    chk({v.name, " done pulses"}, done_cnt, 1);
    if (v.exp_done_k != 0) chk({v.name, " done cycle"}, done_k, v.exp_done_k);
    if (v.whold != 0) chk({v.name, " reads while stalled"}, hold_reads, v.exp_hold_reads);
    chk({v.name, " read count"}, rd_log.size(), v.len);
    chk({v.name, " write count"}, wa_log.size(), v.len);
    for (int i = 0; i < rd_log.size(); i++) begin
      ea = v.src + AW'(i);
      chk($sformatf("%s rd_addr[%0d]", v.name, i), rd_log[i], ea);
    end
    for (int i = 0; i < wa_log.size(); i++) begin
      ea = v.dst + AW'(i);
      chk($sformatf("%s wr_addr[%0d]", v.name, i), wa_log[i], ea);
      ea = v.src + AW'(i);
      chk($sformatf("%s wr_data[%0d]", v.name, i), wd_log[i], img(ea));
    end
    chk({v.name, " r_addr stable"}, r_viol, 0);
    chk({v.name, " w side stable"}, w_viol, 0);
    chk({v.name, " end busy"}, busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " r_avalid"}, r_avalid, 0);
    chk({tag, " w_valid"}, w_valid, 0);
    chk({tag, " r_addr"}, r_addr, 0);
    chk({tag, " w_addr"}, w_addr, 0);
    chk({tag, " w_data"}, w_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rd, n_wr;
    vec_t v;
    vecs[0] = '{"basic",    4'd2,  4'd8,  5'd4,  0,  1'b0, 7,  0};
    vecs[1] = '{"wrap",     4'd14, 4'd15, 5'd3,  0,  1'b0, 6,  0};
    vecs[2] = '{"wstall",   4'd0,  4'd4,  5'd8,  10, 1'b0, 18, 4};
    vecs[3] = '{"rstall",   4'd5,  4'd0,  5'd5,  0,  1'b1, 13, 0};
    vecs[4] = '{"zerolen",  4'd3,  4'd3,  5'd0,  0,  1'b0, 1,  0};
    vecs[5] = '{"fulllen",  4'd1,  4'd0,  5'd16, 0,  1'b0, 19, 0};

    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort a len=6 copy after two writes, then check the block restarts cleanly.
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
    cmd_src = 4'd0; cmd_dst = 4'd6; cmd_len = 5'd6; cmd_valid = 1'b1;
    r_aready = 1'b1; w_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 40 && wa_log.size() < 2; k++) @(negedge clk);
    chk("midrst two writes seen", wa_log.size(), 2);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    n_rd = rd_log.size();
    n_wr = wa_log.size();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    inj_d = 32'hDEAD_BEEF;
    inj_v = 1'b1;
    @(negedge clk);
    inj_v = 1'b0;
    chk("stale w_valid", w_valid, 0);
    chk("stale busy", busy, 0);
    @(negedge clk);
    chk("stale w_valid later", w_valid, 0);
    chk("no reads after abort", rd_log.size(), n_rd);
    chk("no writes after abort", wa_log.size(), n_wr);
    v = '{"afterrst", 4'd3, 4'd12, 5'd1, 0, 1'b0, 4, 0};
    run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
